// File: rtl/au_nibble_seq_if.sv
// au_nibble_seq_if: request, downstream 4-bit AU and result signals of au_nibble_seq
//   start/op/a_in/b_in       : operation request (requester -> sequencer)
//   au_a/au_b/au_sel         : nibble operands and opcode (sequencer -> AU)
//   au_out/au_cout/au_z      : combinational AU result (AU -> sequencer)
//   result/carry/zero/busy/done : final word and status (sequencer -> requester)
interface au_nibble_seq_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [3:0]   au_a;
  logic [3:0]   au_b;
  logic [2:0]   au_sel;
  logic [3:0]   au_out;
  logic         au_cout;
  logic         au_z;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         busy;
  logic         done;
  modport slave (
    input  start, op, a_in, b_in, au_out, au_cout, au_z,
    output au_a, au_b, au_sel, result, carry, zero, busy, done
  );
  modport master (
    output start, op, a_in, b_in, au_out, au_cout, au_z,
    input  au_a, au_b, au_sel, result, carry, zero, busy, done
  );
endinterface

// File: rtl/au_nibble_seq.sv
// au_nibble_seq: runs a W-bit add/sub through an external 4-bit AU one nibble per cycle
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : au_nibble_seq_if.slave (request, AU drive/return, result and status)
module au_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input logic            clk,
  input logic            rst_n,
  au_nibble_seq_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t        r_state, w_next;
  logic [W-1:0]  r_a, r_b, r_result;
  logic          r_op, r_carry, r_zacc, r_zero;
  logic [IW-1:0] r_idx;
  logic          w_run, w_last, w_accept;
  logic [3:0]    w_au_a, w_au_b;
  logic [2:0]    w_sel;
  always_comb begin
    w_run    = r_state == S_RUN;
    w_accept = r_state == S_IDLE && bus.start;
    w_last   = r_idx == IW'(NIBBLES - 1);
    w_next   = w_accept ? S_RUN : (w_run && !w_last) ? S_RUN : w_run ? S_DONE : S_IDLE;
    w_au_a   = w_run ? r_a[{r_idx, 2'b00} +: 4] : 4'd0;
    w_au_b   = w_run ? r_b[{r_idx, 2'b00} +: 4] : 4'd0;
    // 1/2 on the first slice, 5/6 (chain carry/borrow) on the rest
    w_sel    = w_run ? {|r_idx, r_op, ~r_op} : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= bus.a_in;
        r_b    <= bus.b_in;
        r_op   <= bus.op;
        r_idx  <= '0;
        r_zacc <= 1'b1;
      end else if (w_run) begin
        r_result[{r_idx, 2'b00} +: 4] <= bus.au_out;
        r_carry <= bus.au_cout;
        r_zacc  <= r_zacc & bus.au_z;
        // zero output only moves on the last slice so it holds the previous word until then
        if (w_last) r_zero <= r_zacc & bus.au_z;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end
  assign bus.au_a   = w_au_a;
  assign bus.au_b   = w_au_b;
  assign bus.au_sel = w_sel;
  assign bus.result = r_result;
  assign bus.carry  = r_carry;
  assign bus.zero   = r_zero;
  assign bus.busy   = w_run;
  assign bus.done   = r_state == S_DONE;
endmodule

// File: tb/tb_au_nibble_seq.sv
// tb_au_nibble_seq: scoreboard bench for au_nibble_seq with a cycle-accurate 4-bit AU model
module tb_au_nibble_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  au_nibble_seq_if #(.NIBBLES(4)) bus();
  au_nibble_seq #(.NIBBLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic       au_c;
  logic [4:0] au_s;
  always_comb begin
    case (bus.au_sel)
      3'd1:    au_s = {1'b0, bus.au_a} + {1'b0, bus.au_b};
      3'd2:    au_s = {1'b0, bus.au_a} - {1'b0, bus.au_b};
      3'd5:    au_s = {1'b0, bus.au_a} + {1'b0, bus.au_b} + {4'd0, au_c};
      3'd6:    au_s = {1'b0, bus.au_a} - {1'b0, bus.au_b} - {4'd0, au_c};
      default: au_s = 5'd0;
    endcase
  end
  always @(posedge clk)
    if (!rst_n) au_c <= 1'b0;
    else if (bus.au_sel != 3'd0) au_c <= au_s[4];
  assign bus.au_out  = au_s[3:0];
  assign bus.au_cout = au_s[4];
  assign bus.au_z    = au_s[3:0] == 4'd0;
  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        z;
    int          t;
  } exp_t;
  exp_t q[$];
  exp_t me;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  function automatic exp_t model(input bit o, input logic [15:0] a, input logic [15:0] b, input int t);
    exp_t e;
    logic [16:0] s;
    s = o ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    e.r = s[15:0];
    e.c = s[16];
    e.z = s[15:0] == 16'd0;
    e.t = t;
    return e;
  endfunction
  always @(negedge clk)
    if (rst_n && bus.done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
      end else begin
        me = q.pop_front();
        chk("result", 32'(bus.result), 32'(me.r));
        chk("carry", 32'(bus.carry), 32'(me.c));
        chk("zero", 32'(bus.zero), 32'(me.z));
        chk("done_cycle", cyc, me.t);
      end
    end
  // cyc read 1 time unit after the accepting edge; done lands 4 counts later
  task automatic issue(input bit o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ec, input logic ez, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.r = er;
    e.c = ec;
    e.z = ez;
    e.t = cyc + 4;
    if (push) q.push_back(e);
  endtask
  task automatic check_run(input logic [2:0] s0, input logic [2:0] s1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("au_sel", 32'(bus.au_sel), 32'(i == 0 ? s0 : s1));
    end
    @(negedge clk);
    chk("busy_in_done", 32'(bus.busy), 32'd0);
  endtask
  initial begin
    logic [15:0] ra, rb;
    bit ro;
    int n;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a_in  = 16'h1111;
    bus.b_in  = 16'h2222;
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_au_sel", 32'(bus.au_sel), 32'd0);
    chk("rst_au_a", 32'(bus.au_a), 32'd0);
    chk("rst_au_b", 32'(bus.au_b), 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    issue(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b1);
    check_run(3'd1, 3'd5);
    issue(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1);
    check_run(3'd1, 3'd5);
    issue(1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    check_run(3'd2, 3'd6);
    issue(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    check_run(3'd2, 3'd6);
    @(negedge clk);
    chk("hold_result", 32'(bus.result), 32'hFFFF);
    chk("hold_carry", 32'(bus.carry), 32'd1);
    issue(1'b0, 16'h0102, 16'h0304, 16'h0406, 1'b0, 1'b0, 1'b1);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 16'hFFFF;
        bus.b_in  = 16'hFFFF;
      end
      if (k == 3) bus.start = 1'b0;
      n += int'(bus.busy);
    end
    chk("busy_cycles", n, 4);
    chk("ignored_start_result", 32'(bus.result), 32'h0406);
    chk("ignored_start_busy", 32'(bus.busy), 32'd0);
    issue(1'b0, 16'hAAAA, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_carry", 32'(bus.carry), 32'd0);
    chk("abort_au_sel", 32'(bus.au_sel), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    issue(1'b1, 16'h5555, 16'hAAAA, 16'hAAAB, 1'b1, 1'b0, 1'b1);
    check_run(3'd2, 3'd6);
    repeat (3) @(negedge clk);
    ro = 1'($urandom);
    ra = 16'($urandom);
    rb = 16'($urandom);
    bus.op    = ro;
    bus.a_in  = ra;
    bus.b_in  = rb;
    bus.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      q.push_back(model(ro, ra, rb, cyc + 4));
      ro = 1'($urandom);
      ra = (i % 17 == 0) ? 16'hFFFF : 16'($urandom);
      rb = (i % 13 == 0) ? ra : 16'($urandom);
      bus.op   = ro;
      bus.a_in = ra;
      bus.b_in = rb;
      repeat (5) @(posedge clk);
    end
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
